// File: rtl/instruction_decoder_if.sv
// Decode port bundle: instruction word and enable in, registered op vectors and raw fields out.
// slave is the decoder side; master is the fetch/consumer side.
interface instruction_decoder_if;
  logic [31:0] instruction_code;
  logic        en;
  logic [31:0] invalid_instruction;
  logic [18:0] alu_op;
  logic [8:0]  jmp_op;
  logic [8:0]  mem_op;
  logic        cust_op;
  logic [5:0]  csr_op;
  logic [7:0]  mechie_op;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  imm_2531;
  logic [19:0] imm_1231;
  logic [11:0] imm_2032;

  modport slave (
    input  instruction_code, en,
    output invalid_instruction, alu_op, jmp_op, mem_op, cust_op, csr_op, mechie_op,
           rd, rs1, rs2, imm_2531, imm_1231, imm_2032
  );

  modport master (
    output instruction_code, en,
    input  invalid_instruction, alu_op, jmp_op, mem_op, cust_op, csr_op, mechie_op,
           rd, rs1, rs2, imm_2531, imm_1231, imm_2032
  );
endinterface

// File: rtl/instruction_decoder.sv
// Registered RV32I + Zicsr + machine-privileged decoder with a custom-opcode hook.
// Exact-match decode into one-hot per-unit vectors; anything unmatched is flagged invalid.
module instruction_decoder (
  input  logic                  clk,
  input  logic                  rst,
  instruction_decoder_if.slave  bus
);

  logic [31:0] word;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  assign word   = bus.instruction_code;
  assign opcode = word[6:0];
  assign funct3 = word[14:12];
  assign funct7 = word[31:25];

  logic [18:0] alu_d, alu_q;
  logic [8:0]  jmp_d, jmp_q;
  logic [8:0]  mem_d, mem_q;
  logic        cust_d, cust_q;
  logic [5:0]  csr_d, csr_q;
  logic [7:0]  mechie_d, mechie_q;
  logic [31:0] invalid_d, invalid_q;
  logic [31:0] word_q;

  always_comb begin
    alu_d    = '0;
    jmp_d    = '0;
    mem_d    = '0;
    cust_d   = 1'b0;
    csr_d    = '0;
    mechie_d = '0;
    case (opcode)
      7'b0010011: begin
        case (funct3)
          3'b000: alu_d[0] = 1'b1;
          3'b010: alu_d[1] = 1'b1;
          3'b011: alu_d[2] = 1'b1;
          3'b100: alu_d[3] = 1'b1;
          3'b110: alu_d[4] = 1'b1;
          3'b111: alu_d[5] = 1'b1;
          3'b001: alu_d[6] = (funct7 == 7'b0000000);
          default: begin
            alu_d[7] = (funct7 == 7'b0000000);
            alu_d[8] = (funct7 == 7'b0100000);
          end
        endcase
      end
      7'b0110011: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  alu_d[9]  = 1'b1;
            3'b001:  alu_d[11] = 1'b1;
            3'b010:  alu_d[12] = 1'b1;
            3'b011:  alu_d[13] = 1'b1;
            3'b100:  alu_d[14] = 1'b1;
            3'b101:  alu_d[15] = 1'b1;
            3'b110:  alu_d[17] = 1'b1;
            default: alu_d[18] = 1'b1;
          endcase
        end else if (funct7 == 7'b0100000) begin
          alu_d[10] = (funct3 == 3'b000);
          alu_d[16] = (funct3 == 3'b101);
        end
      end
      7'b1101111: jmp_d[0] = 1'b1;
      7'b1100111: jmp_d[1] = (funct3 == 3'b000);
      7'b1100011: begin
        case (funct3)
          3'b000:  jmp_d[2] = 1'b1;
          3'b001:  jmp_d[3] = 1'b1;
          3'b100:  jmp_d[4] = 1'b1;
          3'b101:  jmp_d[5] = 1'b1;
          3'b110:  jmp_d[6] = 1'b1;
          3'b111:  jmp_d[7] = 1'b1;
          default: ;
        endcase
      end
      7'b0010111: jmp_d[8] = 1'b1;
      7'b0000011: begin
        case (funct3)
          3'b000:  mem_d[0] = 1'b1;
          3'b001:  mem_d[1] = 1'b1;
          3'b010:  mem_d[2] = 1'b1;
          3'b100:  mem_d[3] = 1'b1;
          3'b101:  mem_d[4] = 1'b1;
          default: ;
        endcase
      end
      7'b0100011: begin
        case (funct3)
          3'b000:  mem_d[5] = 1'b1;
          3'b001:  mem_d[6] = 1'b1;
          3'b010:  mem_d[7] = 1'b1;
          default: ;
        endcase
      end
      7'b0110111: mem_d[8] = 1'b1;
      7'b0001111: begin
        mechie_d[6] = (funct3 == 3'b000);
        mechie_d[7] = (funct3 == 3'b001);
      end
      7'b1110011: begin
        case (funct3)
          3'b001: csr_d[0] = 1'b1;
          3'b010: csr_d[1] = 1'b1;
          3'b011: csr_d[2] = 1'b1;
          3'b101: csr_d[3] = 1'b1;
          3'b110: csr_d[4] = 1'b1;
          3'b111: csr_d[5] = 1'b1;
          3'b000: begin
            // privileged ops are identified by the whole word, not just funct fields
            case (word)
              32'h0000_0073: mechie_d[0] = 1'b1;
              32'h0010_0073: mechie_d[1] = 1'b1;
              32'h0020_0073: mechie_d[2] = 1'b1;
              32'h1020_0073: mechie_d[3] = 1'b1;
              32'h3020_0073: mechie_d[4] = 1'b1;
              32'h1050_0073: mechie_d[5] = 1'b1;
              default: ;
            endcase
          end
          default: ;
        endcase
      end
      7'b1111111: cust_d = 1'b1;
      default: ;
    endcase
    invalid_d = (|{alu_d, jmp_d, mem_d, cust_d, csr_d, mechie_d}) ? 32'h0 : 32'hFFFF_FFFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_q     <= '0;
      jmp_q     <= '0;
      mem_q     <= '0;
      cust_q    <= 1'b0;
      csr_q     <= '0;
      mechie_q  <= '0;
      invalid_q <= '0;
      word_q    <= '0;
    end else if (bus.en) begin
      alu_q     <= alu_d;
      jmp_q     <= jmp_d;
      mem_q     <= mem_d;
      cust_q    <= cust_d;
      csr_q     <= csr_d;
      mechie_q  <= mechie_d;
      invalid_q <= invalid_d;
      word_q    <= word;
    end
  end

  assign bus.invalid_instruction = invalid_q;
  assign bus.alu_op              = alu_q;
  assign bus.jmp_op              = jmp_q;
  assign bus.mem_op              = mem_q;
  assign bus.cust_op             = cust_q;
  assign bus.csr_op              = csr_q;
  assign bus.mechie_op           = mechie_q;
  assign bus.rd                  = word_q[11:7];
  assign bus.rs1                 = word_q[19:15];
  assign bus.rs2                 = word_q[24:20];
  assign bus.imm_2531            = word_q[31:25];
  assign bus.imm_1231            = word_q[31:12];
  assign bus.imm_2032            = word_q[31:20];

endmodule

// File: tb/tb_instruction_decoder.sv
// Bench for instruction_decoder: directed words plus random words checked against a
// mask/match opcode table model with a one-cycle registered hold/reset shadow.
module tb_instruction_decoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_decoder_if dif ();

  instruction_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  typedef struct packed {
    logic [31:0] inv;
    logic [18:0] alu;
    logic [8:0]  jmp;
    logic [8:0]  mem;
    logic        cust;
    logic [5:0]  csr;
    logic [7:0]  mech;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  i2531;
    logic [19:0] i1231;
    logic [11:0] i2032;
  } exp_t;

  int total = 0;
  int bad = 0;
  logic [31:0] cur_word;
  exp_t exp_q;

  // unit codes: 0 alu, 1 jmp, 2 mem, 3 cust, 4 csr, 5 mechie
  logic [31:0] r_mask [64];
  logic [31:0] r_match[64];
  int          r_unit [64];
  int          r_bit  [64];
  int          nr = 0;

  task automatic add_rule(input logic [31:0] m, input logic [31:0] v, input int u, input int b);
    r_mask[nr]  = m;
    r_match[nr] = v;
    r_unit[nr]  = u;
    r_bit[nr]   = b;
    nr++;
  endtask

  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    e = '0;
    for (int i = 0; i < nr; i++) begin
      if ((w & r_mask[i]) == r_match[i]) begin
        case (r_unit[i])
          0: e.alu[r_bit[i]]  = 1'b1;
          1: e.jmp[r_bit[i]]  = 1'b1;
          2: e.mem[r_bit[i]]  = 1'b1;
          3: e.cust           = 1'b1;
          4: e.csr[r_bit[i]]  = 1'b1;
          default: e.mech[r_bit[i]] = 1'b1;
        endcase
      end
    end
    if ({e.alu, e.jmp, e.mem, e.cust, e.csr, e.mech} == '0) e.inv = 32'hFFFF_FFFF;
    e.rd    = w[11:7];
    e.rs1   = w[19:15];
    e.rs2   = w[24:20];
    e.i2531 = w[31:25];
    e.i1231 = w[31:12];
    e.i2032 = w[31:20];
    return e;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s word=%08h got=%08h exp=%08h", tag, cur_word, got, exp);
    end
  endtask

  task automatic check_all();
    check_val("invalid", dif.invalid_instruction, exp_q.inv);
    check_val("alu_op", dif.alu_op, exp_q.alu);
    check_val("jmp_op", dif.jmp_op, exp_q.jmp);
    check_val("mem_op", dif.mem_op, exp_q.mem);
    check_val("cust_op", dif.cust_op, exp_q.cust);
    check_val("csr_op", dif.csr_op, exp_q.csr);
    check_val("mechie_op", dif.mechie_op, exp_q.mech);
    check_val("rd", dif.rd, exp_q.rd);
    check_val("rs1", dif.rs1, exp_q.rs1);
    check_val("rs2", dif.rs2, exp_q.rs2);
    check_val("imm_2531", dif.imm_2531, exp_q.i2531);
    check_val("imm_1231", dif.imm_1231, exp_q.i1231);
    check_val("imm_2032", dif.imm_2032, exp_q.i2032);
  endtask

  task automatic cycle(input logic r, input logic e, input logic [31:0] w);
    rst = r;
    dif.en = e;
    dif.instruction_code = w;
    cur_word = w;
    @(posedge clk);
    if (r) exp_q = '0;
    else if (e) exp_q = model(w);
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] w;
    int sel, k, i;
    for (int b = 0; b < 6; b++) begin
      add_rule(32'h0000_707F, 32'h0000_0013 | ({29'h0, b[2:0]} << 12), 0, 0);
    end
    // remap the OP-IMM funct3 rules above onto their proper one-hot bits
    r_match[0] = 32'h0000_0013; r_bit[0] = 0;
    r_match[1] = 32'h0000_2013; r_bit[1] = 1;
    r_match[2] = 32'h0000_3013; r_bit[2] = 2;
    r_match[3] = 32'h0000_4013; r_bit[3] = 3;
    r_match[4] = 32'h0000_6013; r_bit[4] = 4;
    r_match[5] = 32'h0000_7013; r_bit[5] = 5;
    add_rule(32'hFE00_707F, 32'h0000_1013, 0, 6);
    add_rule(32'hFE00_707F, 32'h0000_5013, 0, 7);
    add_rule(32'hFE00_707F, 32'h4000_5013, 0, 8);
    add_rule(32'hFE00_707F, 32'h0000_0033, 0, 9);
    add_rule(32'hFE00_707F, 32'h4000_0033, 0, 10);
    add_rule(32'hFE00_707F, 32'h0000_1033, 0, 11);
    add_rule(32'hFE00_707F, 32'h0000_2033, 0, 12);
    add_rule(32'hFE00_707F, 32'h0000_3033, 0, 13);
    add_rule(32'hFE00_707F, 32'h0000_4033, 0, 14);
    add_rule(32'hFE00_707F, 32'h0000_5033, 0, 15);
    add_rule(32'hFE00_707F, 32'h4000_5033, 0, 16);
    add_rule(32'hFE00_707F, 32'h0000_6033, 0, 17);
    add_rule(32'hFE00_707F, 32'h0000_7033, 0, 18);
    add_rule(32'h0000_007F, 32'h0000_006F, 1, 0);
    add_rule(32'h0000_707F, 32'h0000_0067, 1, 1);
    add_rule(32'h0000_707F, 32'h0000_0063, 1, 2);
    add_rule(32'h0000_707F, 32'h0000_1063, 1, 3);
    add_rule(32'h0000_707F, 32'h0000_4063, 1, 4);
    add_rule(32'h0000_707F, 32'h0000_5063, 1, 5);
    add_rule(32'h0000_707F, 32'h0000_6063, 1, 6);
    add_rule(32'h0000_707F, 32'h0000_7063, 1, 7);
    add_rule(32'h0000_007F, 32'h0000_0017, 1, 8);
    add_rule(32'h0000_707F, 32'h0000_0003, 2, 0);
    add_rule(32'h0000_707F, 32'h0000_1003, 2, 1);
    add_rule(32'h0000_707F, 32'h0000_2003, 2, 2);
    add_rule(32'h0000_707F, 32'h0000_4003, 2, 3);
    add_rule(32'h0000_707F, 32'h0000_5003, 2, 4);
    add_rule(32'h0000_707F, 32'h0000_0023, 2, 5);
    add_rule(32'h0000_707F, 32'h0000_1023, 2, 6);
    add_rule(32'h0000_707F, 32'h0000_2023, 2, 7);
    add_rule(32'h0000_007F, 32'h0000_0037, 2, 8);
    add_rule(32'h0000_007F, 32'h0000_007F, 3, 0);
    add_rule(32'h0000_707F, 32'h0000_1073, 4, 0);
    add_rule(32'h0000_707F, 32'h0000_2073, 4, 1);
    add_rule(32'h0000_707F, 32'h0000_3073, 4, 2);
    add_rule(32'h0000_707F, 32'h0000_5073, 4, 3);
    add_rule(32'h0000_707F, 32'h0000_6073, 4, 4);
    add_rule(32'h0000_707F, 32'h0000_7073, 4, 5);
    add_rule(32'hFFFF_FFFF, 32'h0000_0073, 5, 0);
    add_rule(32'hFFFF_FFFF, 32'h0010_0073, 5, 1);
    add_rule(32'hFFFF_FFFF, 32'h0020_0073, 5, 2);
    add_rule(32'hFFFF_FFFF, 32'h1020_0073, 5, 3);
    add_rule(32'hFFFF_FFFF, 32'h3020_0073, 5, 4);
    add_rule(32'hFFFF_FFFF, 32'h1050_0073, 5, 5);
    add_rule(32'h0000_707F, 32'h0000_000F, 5, 6);
    add_rule(32'h0000_707F, 32'h0000_100F, 5, 7);

    exp_q = '0;
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h0);
    check_val("reset_inv", dif.invalid_instruction, 32'h0);

    cycle(1'b0, 1'b1, 32'h0000_0000);
    check_val("zero_inv", dif.invalid_instruction, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b1, 32'h0000_0797);
    check_val("auipc_jmp", dif.jmp_op, 32'h100);
    check_val("auipc_rd", dif.rd, 32'd15);
    cycle(1'b0, 1'b1, 32'h02C7_8793);
    check_val("addi_alu", dif.alu_op, 32'h00001);
    check_val("addi_imm", dif.imm_2032, 32'h02C);
    cycle(1'b0, 1'b1, 32'h07F5_6513);
    check_val("ori_alu", dif.alu_op, 32'h00010);
    cycle(1'b0, 1'b1, 32'h3057_93F3);
    check_val("csrrw_csr", dif.csr_op, 32'h01);
    check_val("csrrw_imm", dif.imm_2032, 32'h305);
    cycle(1'b0, 1'b1, 32'h3020_0073);
    check_val("mret_mech", dif.mechie_op, 32'h10);
    cycle(1'b0, 1'b1, 32'h1A50_00EF);
    check_val("jal_jmp", dif.jmp_op, 32'h001);
    check_val("jal_imm", dif.imm_1231, 32'h1A500);
    cycle(1'b0, 1'b1, 32'h0407_9263);
    check_val("bne_jmp", dif.jmp_op, 32'h008);
    check_val("bne_imm", dif.imm_2531, 32'h02);
    cycle(1'b0, 1'b1, 32'h8000_007F);
    check_val("cust", dif.cust_op, 32'h1);
    cycle(1'b0, 1'b1, 32'h0011_2623);
    check_val("sw_mem", dif.mem_op, 32'h080);
    check_val("sw_rd", dif.rd, 32'd12);
    cycle(1'b0, 1'b0, 32'h0000_0000);
    check_val("hold_mem", dif.mem_op, 32'h080);
    check_val("hold_inv", dif.invalid_instruction, 32'h0);
    cycle(1'b1, 1'b1, 32'h02C7_8793);
    check_val("rst_en_alu", dif.alu_op, 32'h0);
    cycle(1'b0, 1'b1, 32'h0000_C063);
    check_val("blt_jmp", dif.jmp_op, 32'h010);
    cycle(1'b0, 1'b1, 32'h0000_2063);
    check_val("br010_inv", dif.invalid_instruction, 32'hFFFF_FFFF);

    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 9);
      i = $urandom_range(0, nr - 1);
      w = ($urandom() & ~r_mask[i]) | r_match[i];
      if (sel == 6 || sel == 7) begin
        k = $urandom_range(0, 31);
        while (!r_mask[i][k]) k = $urandom_range(0, 31);
        w[k] = ~w[k];
      end else if (sel >= 8) begin
        w = $urandom();
      end
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0), w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
